// File: rtl/gr0040_intc.sv
// Interrupt controller for the gr0040 core: synchronised edge capture, pend/mask, fixed priority, iret retire.
// Optional software-triggered interrupts via the SWI register are enabled by defining INTC_SWI_EN.
module gr0040_intc #(
    parameter int          NSRC      = 8,
    parameter logic [15:0] VEC_BASE  = 16'h0020,
    parameter int          VEC_SHIFT = 2,
    parameter logic [15:0] MMIO_BASE = 16'hFF40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic            int_en,
    input  logic            insn_ce,
    input  logic            iret_detected,
    output logic            irq_take,
    output logic [15:0]     irq_vector,
    input  logic [15:0]     d_ad,
    input  logic            lw,
    input  logic            lb,
    input  logic            sw,
    input  logic            sb,
    input  logic [15:0]     wdata,
    output logic            sel,
    output logic [15:0]     rdata,
    output logic            rdy
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_SERVICE = 1'b1;

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_SWI  = 2'd3;

    logic [NSRC-1:0] sync1_r;
    logic [NSRC-1:0] sync2_r;
    logic [NSRC-1:0] prev_r;
    logic [NSRC-1:0] pend_r;
    logic [NSRC-1:0] mask_r;
    logic [3:0]      act_id_r;
    logic [0:0]      state_r;

    logic [NSRC-1:0] edge_s;
    logic [NSRC-1:0] elig_s;
    logic [NSRC-1:0] take_clr_s;
    logic [NSRC-1:0] pend_nxt_s;
    logic [NSRC-1:0] mask_nxt_s;
    logic [3:0]      id_s;
    logic [3:0]      act_id_nxt_s;
    logic [0:0]      state_nxt_s;
    logic            take_s;
    logic            sel_s;
    logic            rd_s;
    logic            wr_pend_s;
    logic            wr_mask_s;
    logic [15:0]     rdata_s;
    logic            unused_s;

    // Lowest set index wins; the scan runs high to low so the last hit is the lowest.
    function automatic logic [3:0] lowest_index(input logic [NSRC-1:0] v);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [15:0] zext(input logic [NSRC-1:0] v);
        logic [15:0] r;
        r = 16'h0000;
        r[NSRC-1:0] = v;
        return r;
    endfunction

    assign edge_s   = sync2_r & ~prev_r;
    assign elig_s   = pend_r & mask_r;
    assign id_s     = lowest_index(elig_s);
    assign take_s   = (state_r == ST_IDLE) & (|elig_s) & int_en & insn_ce;
    assign sel_s    = (d_ad[15:3] == MMIO_BASE[15:3]);
    assign rd_s     = (lw | lb) & sel_s;
    assign wr_pend_s = sw & sel_s & (d_ad[2:1] == REG_PEND);
    assign wr_mask_s = sw & sel_s & (d_ad[2:1] == REG_MASK);

    // Byte enable, byte-address LSB and store data above NSRC carry no meaning here.
    assign unused_s = ^{sb, d_ad[0], wdata};

    assign irq_take   = take_s;
    assign irq_vector = VEC_BASE + (16'(id_s) << VEC_SHIFT);
    assign sel        = sel_s;
    assign rdata      = rdata_s;
    assign rdy        = 1'b1;

    // One-hot clear for the source being taken this cycle.
    always_comb begin
        take_clr_s = '0;
        for (int i = 0; i < NSRC; i++) begin
            take_clr_s[i] = take_s & (id_s == 4'(i));
        end
    end

`ifdef INTC_SWI_EN
    logic wr_swi_s;
    assign wr_swi_s = sw & sel_s & (d_ad[2:1] == REG_SWI);
`endif

    // Pending next state: clears first, then sets, so a hardware edge always survives a clear.
    always_comb begin
        pend_nxt_s = pend_r;
        if (wr_pend_s) begin
            pend_nxt_s = pend_nxt_s & ~wdata[NSRC-1:0];
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
`ifdef INTC_SWI_EN
        if (wr_swi_s) begin
            pend_nxt_s = pend_nxt_s | wdata[NSRC-1:0];
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
`endif
        pend_nxt_s = (pend_nxt_s & ~take_clr_s) | edge_s;
    end

    // Mask register update.
    always_comb begin
        mask_nxt_s = mask_r;
        if (wr_mask_s) begin
            mask_nxt_s = wdata[NSRC-1:0];
        end else begin
            mask_nxt_s = mask_r;
        end
    end

    // Service FSM; interrupts do not nest, SERVICE only leaves on a clocked iret.
    always_comb begin
        state_nxt_s  = state_r;
        act_id_nxt_s = act_id_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_nxt_s  = ST_SERVICE;
                    act_id_nxt_s = id_s;
                end else begin
                    state_nxt_s  = ST_IDLE;
                    act_id_nxt_s = act_id_r;
                end
            end
            ST_SERVICE: begin
                if (iret_detected & insn_ce) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                act_id_nxt_s = 4'h0;
            end
        endcase
    end

    // Register window read mux; zero whenever the window is not being read.
    always_comb begin
        rdata_s = 16'h0000;
        if (rd_s) begin
            case (d_ad[2:1])
                REG_PEND: rdata_s = zext(pend_r);
                REG_MASK: rdata_s = zext(mask_r);
                REG_STAT: rdata_s = {10'b0, (state_r == ST_SERVICE), 1'b0, act_id_r};
                REG_SWI:  rdata_s = 16'h0000;
                default:  rdata_s = 16'h0000;
            endcase
        end else begin
            rdata_s = 16'h0000;
        end
    end

    // Two-flop synchroniser plus previous-value flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
            prev_r  <= '0;
        end else begin
            sync1_r <= irq_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            pend_r   <= '0;
            mask_r   <= '0;
            act_id_r <= 4'h0;
        end else begin
            state_r  <= state_nxt_s;
            pend_r   <= pend_nxt_s;
            mask_r   <= mask_nxt_s;
            act_id_r <= act_id_nxt_s;
        end
    end

endmodule

// File: tb/tb_gr0040_intc.sv
// Scoreboard bench for gr0040_intc: stimulus queues expected takes/reads, a negedge monitor checks them.
module tb_gr0040_intc;

    localparam logic [15:0] A_PEND = 16'hFF40;
    localparam logic [15:0] A_MASK = 16'hFF42;
    localparam logic [15:0] A_STAT = 16'hFF44;
    localparam logic [15:0] A_SWI  = 16'hFF46;

    typedef struct {
        logic [15:0] val;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        int_en, insn_ce, iret_detected;
    logic        irq_take;
    logic [15:0] irq_vector;
    logic [15:0] d_ad, wdata, rdata;
    logic        lw, lb, sw, sb, sel, rdy;

    exp_t take_q[$];
    exp_t rd_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    gr0040_intc dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .int_en(int_en), .insn_ce(insn_ce),
        .iret_detected(iret_detected), .irq_take(irq_take), .irq_vector(irq_vector),
        .d_ad(d_ad), .lw(lw), .lb(lb), .sw(sw), .sb(sb), .wdata(wdata),
        .sel(sel), .rdata(rdata), .rdy(rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every take and every window read must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (irq_take) begin
                checks++;
                if (take_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_take vector=%h cyc=%0d required no take", irq_vector, cyc);
                end else begin
                    exp_t e;
                    e = take_q.pop_front();
                    if (irq_vector !== e.val || (e.cyc >= 0 && cyc != e.cyc)) begin
                        errors++;
                        $display("FAIL %s vector=%h cyc=%0d required vector=%h cyc=%0d",
                                 e.name, irq_vector, cyc, e.val, e.cyc);
                    end
                end
            end
            if ((lw | lb) && sel) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read rdata=%h required no read", rdata);
                end else begin
                    exp_t e;
                    e = rd_q.pop_front();
                    if (rdata !== e.val) begin
                        errors++;
                        $display("FAIL %s rdata=%h required %h", e.name, rdata, e.val);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h required %h", name, act, req);
        end
    endtask

    task automatic expect_take(input string name, input logic [15:0] vec, input int at_cyc);
        exp_t e;
        e.val = vec; e.cyc = at_cyc; e.name = name;
        take_q.push_back(e);
    endtask

    task automatic rd(input string name, input logic [15:0] addr, input logic use_lb,
                      input logic [15:0] req);
        exp_t e;
        e.val = req; e.cyc = -1; e.name = name;
        rd_q.push_back(e);
        d_ad = addr;
        lw = ~use_lb;
        lb = use_lb;
        tick(1);
        lw = 1'b0;
        lb = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        d_ad = addr;
        wdata = data;
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
    endtask

    task automatic iret();
        iret_detected = 1'b1;
        tick(1);
        iret_detected = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; irq_in = 8'h00; int_en = 1'b1; insn_ce = 1'b1; iret_detected = 1'b0;
        d_ad = 16'h0000; wdata = 16'h0000; lw = 1'b0; lb = 1'b0; sw = 1'b0; sb = 1'b0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_take", {15'b0, irq_take}, 16'h0000);
        chk("reset_vector", irq_vector, 16'h0020);
        chk("reset_rdata", rdata, 16'h0000);
        chk("rdy_tied", {15'b0, rdy}, 16'h0001);
        tick(1);
        rd("reset_pend", A_PEND, 1'b0, 16'h0000);
        rd("reset_mask", A_MASK, 1'b0, 16'h0000);
        rd("reset_stat", A_STAT, 1'b0, 16'h0000);

        // Address decode edges and deselected read.
        d_ad = 16'hFF48; lw = 1'b1; #1;
        chk("sel_above", {15'b0, sel}, 16'h0000);
        chk("rdata_unsel", rdata, 16'h0000);
        d_ad = 16'hFF47; #1;
        chk("sel_top", {15'b0, sel}, 16'h0001);
        lw = 1'b0; #1;
        chk("rdata_no_strobe", rdata, 16'h0000);

        // 1: single source, three-cycle latency.
        wr(A_MASK, 16'h0001);
        n = cyc;
        expect_take("t1_take", 16'h0020, n + 3);
        irq_in = 8'h01;
        tick(2);
        irq_in = 8'h00;
        tick(4);
        rd("t1_stat", A_STAT, 1'b0, 16'h0020);
        rd("t1_pend", A_PEND, 1'b0, 16'h0000);
        iret();
        rd("t1_stat_idle", A_STAT, 1'b0, 16'h0000);

        // Mask readback, upper bits dropped, lb reads full word.
        wr(A_MASK, 16'hFFFF);
        rd("mask_width", A_MASK, 1'b0, 16'h00FF);
        rd("mask_lb", A_MASK, 1'b1, 16'h00FF);

        // 2: two simultaneous edges, priority then retire.
        expect_take("t2_take_id2", 16'h0028, -1);
        irq_in = 8'h24;
        tick(6);
        rd("t2_pend", A_PEND, 1'b0, 16'h0020);
        expect_take("t2_take_id5", 16'h0034, -1);
        iret();
        tick(2);
        rd("t2_stat", A_STAT, 1'b0, 16'h0025);
        iret();
        irq_in = 8'h00;
        tick(2);

        // 3: held off by int_en, taken in the cycle it rises.
        int_en = 1'b0;
        irq_in = 8'h08;
        tick(10);
        rd("t3_pend", A_PEND, 1'b0, 16'h0008);
        expect_take("t3_take", 16'h002C, cyc);
        int_en = 1'b1;
        tick(2);
        iret();
        irq_in = 8'h00;
        tick(2);

        // 4: no nesting, iret in IDLE is ignored.
        expect_take("t4_take_id0", 16'h0020, -1);
        irq_in = 8'h01;
        tick(5);
        irq_in = 8'h03;
        tick(8);
        rd("t4_pend", A_PEND, 1'b0, 16'h0002);
        expect_take("t4_take_id1", 16'h0024, -1);
        iret();
        tick(3);
        iret();
        tick(1);
        iret();
        tick(1);
        rd("t4_stat", A_STAT, 1'b0, 16'h0001);
        irq_in = 8'h00;
        tick(2);

        // 5: edge set beats same-cycle W1C, then W1C alone clears.
        wr(A_MASK, 16'h0000);
        irq_in = 8'h04;
        tick(2);
        wr(A_PEND, 16'h0004);
        rd("t5_set_wins", A_PEND, 1'b0, 16'h0004);
        wr(A_PEND, 16'h0004);
        rd("t5_cleared", A_PEND, 1'b0, 16'h0000);
        irq_in = 8'h00;
        tick(2);

        // 6: software interrupt register.
        wr(A_MASK, 16'h0080);
`ifdef INTC_SWI_EN
        expect_take("t6_swi_take", 16'h003C, -1);
        wr(A_SWI, 16'h0080);
        tick(3);
        rd("t6_stat", A_STAT, 1'b0, 16'h0027);
        iret();
`else
        wr(A_SWI, 16'h0080);
        tick(3);
        rd("t6_pend", A_PEND, 1'b0, 16'h0000);
        rd("t6_swi_read", A_SWI, 1'b0, 16'h0000);
`endif
        tick(5);

        while (take_q.size() > 0) begin
            exp_t e;
            e = take_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s no take seen required vector=%h", e.name, e.val);
        end
        while (rd_q.size() > 0) begin
            exp_t e;
            e = rd_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s no read seen required %h", e.name, e.val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
